// File: rtl/tub_scan_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tub_scan_arbiter_pkg: owner codes, grant codes, seven-segment glyphs  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package tub_scan_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAN   = 2'd1,
    S_AUTO  = 2'd2,
    S_ALERT = 2'd3
  } owner_t;

  localparam logic [2:0] GRANT_IDLE  = 3'b000;
  localparam logic [2:0] GRANT_MAN   = 3'b001;
  localparam logic [2:0] GRANT_AUTO  = 3'b010;
  localparam logic [2:0] GRANT_ALERT = 3'b100;

  // Segment bit order {dp, g, f, e, d, c, b, a}, active high.
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_A     = 8'h77;
  localparam logic [7:0] SEG_B     = 8'h7C;
  localparam logic [7:0] SEG_C     = 8'h39;
  localparam logic [7:0] SEG_D     = 8'h5E;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_F     = 8'h71;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  function automatic logic [2:0] owner_to_grant(input owner_t o);
    case (o)
      S_MAN:   return GRANT_MAN;
      S_AUTO:  return GRANT_AUTO;
      S_ALERT: return GRANT_ALERT;
      default: return GRANT_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/tub_scan_arbiter_seg_decode.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tub_scan_arbiter_seg_decode: 4-bit hex code to seven-segment glyph    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tub_scan_arbiter_seg_decode
  import tub_scan_arbiter_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tub_scan_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tub_scan_arbiter: frame-boundary display arbitration and digit scan   |
// | Optional macro ALERT_BLINK_EN blinks the alert.  Rev 1.0              |
// +-----------------------------------------------------------------------+
module tub_scan_arbiter
  import tub_scan_arbiter_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int ALERT_HOLD   = 250,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_manual,
  input  logic        req_auto,
  input  logic        req_alert,
  input  logic [31:0] data_manual,
  input  logic [31:0] data_auto,
  input  logic [31:0] data_alert,
  output logic [2:0]  grant,
  output logic        alert_done,
  output logic [7:0]  tub_sel,
  output logic [7:0]  tub_ctr1,
  output logic [7:0]  tub_ctr2
);

  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int HOLD_W = $clog2(ALERT_HOLD + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(ALERT_HOLD - 1);

  if (SCAN_DIV < 2 || ALERT_HOLD < 1 || BLINK_FRAMES < 1) begin : g_param_check
    $error("tub_scan_arbiter: illegal parameter value");
  end

  logic [CNT_W-1:0]  presc;
  logic [1:0]        phase;
  logic              tick;
  logic              frame_end;
  owner_t            owner;
  owner_t            owner_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic              armed;
  logic              armed_next;
  logic              alert_stay;
  logic              alert_expire;
  logic              blank_blink;
  logic [31:0]       data_sel;
  logic [31:0]       data_shl;
  logic [7:0]        seg_l;
  logic [7:0]        seg_r;
  logic [7:0]        sel_c;
  logic [7:0]        ctr1_c;
  logic [7:0]        ctr2_c;

  assign tick         = (presc == CNT_MAX);
  assign frame_end    = tick && (phase == 2'd3);
  assign alert_stay   = (owner == S_ALERT) && (hold_cnt < HOLD_MAX);
  assign alert_expire = (owner == S_ALERT) && !alert_stay;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      phase <= 2'd0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) phase <= phase + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= S_IDLE;
      hold_cnt <= '0;
      armed    <= 1'b1;
    end else begin
      owner    <= owner_next;
      hold_cnt <= hold_next;
      armed    <= armed_next;
    end
  end

  // An expiring alert falls through to the normal priority chain as if it
  // were not requesting, so a level-held alert cannot immediately re-grab.
  always_comb begin
    owner_next = owner;
    hold_next  = hold_cnt;
    armed_next = armed;
    if (frame_end) begin
      if (alert_stay) begin
        hold_next = hold_cnt + 1'b1;
      end else if (req_alert && armed && !alert_expire) begin
        owner_next = S_ALERT;
        hold_next  = '0;
      end else if (req_auto) begin
        owner_next = S_AUTO;
      end else if (req_manual) begin
        owner_next = S_MAN;
      end else begin
        owner_next = S_IDLE;
      end
      if (!req_alert)        armed_next = 1'b1;
      else if (alert_expire) armed_next = 1'b0;
    end
  end

  assign alert_done = frame_end && alert_expire && !rst;
  assign grant      = owner_to_grant(owner);

`ifdef ALERT_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_FRAMES - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (frame_end) begin
      if (owner != S_ALERT) begin
        blink_cnt <= '0;
        blink     <= 1'b0;
      end else if (blink_cnt == BLINK_MAX) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blank_blink = blink && (owner == S_ALERT);
`else
  assign blank_blink = 1'b0;
`endif

  always_comb begin
    case (owner)
      S_MAN:   data_sel = data_manual;
      S_AUTO:  data_sel = data_auto;
      S_ALERT: data_sel = data_alert;
      default: data_sel = 32'h0;
    endcase
  end

  // Shifting by 4*phase brings the current digit of each group to the top nibble.
  assign data_shl = data_sel << {phase, 2'b00};

  tub_scan_arbiter_seg_decode u_seg_ctr1 (
    .code (data_shl[31:28]),
    .seg  (seg_l)
  );

  tub_scan_arbiter_seg_decode u_seg_ctr2 (
    .code (data_shl[15:12]),
    .seg  (seg_r)
  );

  always_comb begin
    sel_c  = 8'h00;
    ctr1_c = SEG_BLANK;
    ctr2_c = SEG_BLANK;
    if (owner != S_IDLE) begin
      ctr1_c = seg_l;
      ctr2_c = seg_r;
      if (!tick && !blank_blink) sel_c = (8'h80 >> phase) | (8'h08 >> phase);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tub_sel  <= 8'h00;
      tub_ctr1 <= 8'h00;
      tub_ctr2 <= 8'h00;
    end else begin
      tub_sel  <= sel_c;
      tub_ctr1 <= ctr1_c;
      tub_ctr2 <= ctr2_c;
    end
  end

endmodule
`default_nettype wire

// File: doc/tub_scan_arbiter.md
Name: tub_scan_arbiter

Overview:
Time-multiplexed scan controller for the two 4-digit seven-segment groups (tub_sel, tub_ctr1, tub_ctr2).
- Arbitrates display ownership between three requesters: manual status, auto script view, and alert message.
- Generates the digit-scan timing and per-digit segment drive for the owning source.
- Sits between the manual/auto control logic and the board tube pins; replaces ad-hoc per-mode tube muxing.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit phase; 1 kHz phase rate at 100 MHz. Legal values are ≥2.
- ALERT_HOLD, 250: number of complete frames an alert owns the display once granted. Legal values are ≥1.
- BLINK_FRAMES, 64: frames per blink half-period; used only with ALERT_BLINK_EN.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- req_manual, input, 1: manual source requests the display (level).
- req_auto, input, 1: auto source requests the display (level).
- req_alert, input, 1: alert source requests the display (level).
- data_manual, input, 32: eight 4-bit digit codes; [31:28] is the leftmost digit.
- data_auto, input, 32: same format as data_manual.
- data_alert, input, 32: same format as data_manual.
- grant, output, 3: one-hot current owner, {alert, auto, manual}; 000 means idle.
- alert_done, output, 1: one-cycle pulse when the alert hold expires.
- tub_sel, output, 8: active-high digit enables.
- tub_ctr1, output, 8: segment drive for the left group (digits 7..4).
- tub_ctr2, output, 8: segment drive for the right group (digits 3..0).

Behaviour:
- Reset state: prescaler=0, phase=0, owner=IDLE, hold counter=0, alert_armed=1. All outputs are 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - tick is asserted when the count equals SCAN_DIV-1, then the count wraps to 0.
  - On tick, phase advances 0→1→2→3→0.
  - frame_end = tick while phase==3.
- Owner FSM (IDLE, MANUAL, AUTO, ALERT): changes state only at frame_end. Decision order:
  - If owner==ALERT and hold counter < ALERT_HOLD-1: stay in ALERT and increment the hold counter.
  - If owner==ALERT and the hold is expiring: pulse alert_done on this cycle, clear alert_armed, then fall through to the rules below, treating alert as not requesting.
  - If req_alert && alert_armed: go to ALERT and set hold counter=0.
  - Else if req_auto: go to AUTO.
  - Else if req_manual: go to MANUAL.
  - Else: go to IDLE.
- alert_armed is set at any frame_end where req_alert is sampled low. A level-held req_alert therefore cannot immediately re-grab the display.
- Requests are sampled only at frame_end. Deasserting a request mid-frame has no effect until the boundary. This includes req_alert: once granted, the alert always completes its hold.
- grant is registered and equals the owner state, so it updates on the cycle after frame_end.
- Output stage (registered, one cycle latency from the phase/owner change):
  - The selected data word D comes from the owner.
  - For phase p: tub_sel has bits (7-p) and (3-p) set. tub_ctr1 = seg(D[31-4p -: 4]). tub_ctr2 = seg(D[15-4p -: 4]).
  - Anti-ghosting: on the cycle where tick is high, the next-cycle tub_sel is 0. Each phase therefore shows exactly one blank cycle followed by SCAN_DIV-1 lit cycles.
  - Owner IDLE: tub_sel=0 and tub_ctr1/2=0 while phase keeps running.
- Segment decode is combinational from a 4-bit code using the shared pattern table: codes 0-F map to hex glyphs.
- Reset mid-operation: all state returns to reset values on the next clk edge, and any pending alert_done is suppressed.

Optional Feature:
ALERT_BLINK_EN:
- Defined: while owner==ALERT, a frame counter toggles a blink flag every BLINK_FRAMES frames; the flag is cleared on grant. While the flag is high, tub_sel is forced to 0. Hold counting and alert_done are unaffected.
- Undefined: no blink counter and no blink logic; the alert is displayed steadily.

Decomposition:
- Shared constants file Constant.v:
  - owner state codes S_IDLE, S_MAN, S_AUTO, S_ALERT.
  - grant one-hot codes.
  - 16 seven-segment glyph patterns SEG_0..SEG_F.
  - blank pattern.
- One sub-module, seg_decode: 4-bit code in, 8-bit segment out, purely combinational. Two instances are used, one for ctr1 and one for ctr2.

Test Plan (SCAN_DIV=4, ALERT_HOLD=2, BLINK_FRAMES=1):
- Reset then idle: rst high 3 cycles, no requests → grant=000, tub_sel=0 for ≥40 cycles; phase still advances every 4 cycles.
- Manual scan: req_manual=1, data_manual=32'h1234_5678 → after the first frame_end, grant=001. Phase 0: tub_sel=8'h88, ctr1=SEG_1, ctr2=SEG_5. Phase 3: tub_sel=8'h11, ctr1=SEG_4, ctr2=SEG_8. Each phase has 1 blank cycle and 3 lit cycles.
- Priority: req_manual=req_auto=1, raised mid-frame → grant stays unchanged until frame_end, then grant=010.
- Alert hold: req_alert pulsed high at one frame_end only → grant=100 for exactly 2 frames (32 cycles). alert_done is pulsed once, then grant reverts to the highest other requester.
- Re-arm: req_alert held high throughout → after alert_done, no re-grant; drop req_alert for one frame_end and raise it again → alert re-granted at the next frame_end.
- Mid-alert reset: assert rst during ALERT → next cycle grant=000, tub_sel=0, no alert_done pulse.
